phy_regfile_ext: RTL and testbench

Parametrised PHY management register file: the register target that the MDIO peripheral accesses through its address/data/strobe interface. It generalises the flat 32×16 PHY register bank in three ways: configurable width and depth, a registered read handshake, and IEEE-style register semantics. Those semantics are a read-only status register with a latched-low link bit, and a self-clearing soft-reset bit that runs a timed reset sequence.

---
 rtl/phy_regfile_ext.sv | 164 ++++++++++++++++
 tb/tb_phy_regfile_ext.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/phy_regfile_ext.sv
// phy_regfile_ext: PHY management register file behind the MDIO peripheral.
// Register 0 is CONTROL (its top bit is a self-clearing soft reset), register 1
// is a read-only STATUS word with a latched-low LINK bit, and the remaining
// registers are plain read/write storage. Reads are registered with a
// one-cycle RD_VALID pulse. A soft reset keeps BUSY high for SRST_CYCLES
// cycles and then clears every read/write register.
module phy_regfile_ext #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int NUM_REGS    = 32,
  parameter int SRST_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_STB,
  input  logic              RD_STB,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  input  logic              LINK_UP,
  output logic              BUSY,
  output logic [DATA_W-1:0] CTRL
);

  localparam int CNT_W = $clog2(SRST_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SRST = 1'b1
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;
  logic                link_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_valid_reg;

  // All register contents side by side; slice i holds register i. Slice 1 is
  // the synthesised STATUS word rather than storage.
  logic [NUM_REGS*DATA_W-1:0] reg_flat;
  logic [DATA_W-1:0]          status_word;
  logic [DATA_W-1:0]          rd_mux;

  logic wr_ok;
  logic srst_start;
  logic srst_done;
  logic status_rd;

  // Writes are only accepted outside a soft reset sequence.
  assign wr_ok      = WR_STB && (state_reg == IDLE);
  assign srst_start = wr_ok && (ADDR == '0) && WR_DATA[DATA_W-1];
  // Final cycle of the sequence: the clear happens on this edge.
  assign srst_done  = (state_reg == SRST) && (cnt_reg == CNT_W'(1));
  assign status_rd  = RD_STB && (ADDR == ADDR_W'(1));

  // STATUS word: LINK latch on bit 2, BUSY on bit 0, everything else zero.
  always_comb begin
    status_word    = '0;
    status_word[2] = link_reg;
    status_word[0] = busy_reg;
  end

  // Per-register storage; register 1 has no storage and ignores writes.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 1) begin : g_status
        assign reg_flat[gi*DATA_W +: DATA_W] = status_word;
      end else begin : g_rw
        logic [DATA_W-1:0] q_reg;

        // Hardware reset and soft-reset completion clear; accepted writes load.
        always_ff @(posedge clk) begin
          if (!reset) begin
            q_reg <= '0;
          end else if (srst_done) begin
            q_reg <= '0;
          end else if (wr_ok && (ADDR == ADDR_W'(gi))) begin
            q_reg <= WR_DATA;
          end
        end

        assign reg_flat[gi*DATA_W +: DATA_W] = q_reg;
      end
    end
  endgenerate

  // Read select; addresses beyond the implemented range fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADDR == ADDR_W'(i)) begin
        rd_mux = reg_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read port: captures the pre-edge value, which gives
  // read-before-write on a simultaneous access to the same address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= RD_STB;
      if (RD_STB) begin
        rd_data_reg <= rd_mux;
      end
    end
  end

  // LINK latch: holds a drop until STATUS is read; a read or the end of a
  // soft reset re-arms it from the live LINK_UP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      link_reg <= 1'b0;
    end else if (status_rd || srst_done) begin
      link_reg <= LINK_UP;
    end else begin
      link_reg <= link_reg & LINK_UP;
    end
  end

  // Soft-reset sequencer: counts SRST_CYCLES edges with BUSY high. A second
  // SOFT_RST write cannot restart it because writes are blocked in SRST.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (srst_start) begin
            state_reg <= SRST;
            cnt_reg   <= CNT_W'(SRST_CYCLES);
            busy_reg  <= 1'b1;
          end
        end
        SRST: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign RD_DATA  = rd_data_reg;
  assign RD_VALID = rd_valid_reg;
  assign BUSY     = busy_reg;
  assign CTRL     = reg_flat[DATA_W-1:0];

endmodule

// File: tb/tb_phy_regfile_ext.sv
// Directed bench for phy_regfile_ext: one default instance (32 registers) and
// one with NUM_REGS=20 for the out-of-range address case.
module tb_phy_regfile_ext;

  logic        clk;
  logic        reset;
  logic        link_up;

  logic [4:0]  addr_a;
  logic [15:0] wr_data_a;
  logic        wr_stb_a, rd_stb_a;
  logic [15:0] rd_data_a;
  logic        rd_valid_a, busy_a;
  logic [15:0] ctrl_a;

  logic [4:0]  addr_b;
  logic [15:0] wr_data_b;
  logic        wr_stb_b, rd_stb_b;
  logic [15:0] rd_data_b;
  logic        rd_valid_b, busy_b;
  logic [15:0] ctrl_b;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles;

  phy_regfile_ext dut_a (
    .clk(clk), .reset(reset), .ADDR(addr_a), .WR_DATA(wr_data_a),
    .WR_STB(wr_stb_a), .RD_STB(rd_stb_a), .RD_DATA(rd_data_a),
    .RD_VALID(rd_valid_a), .LINK_UP(link_up), .BUSY(busy_a), .CTRL(ctrl_a)
  );

  phy_regfile_ext #(.NUM_REGS(20)) dut_b (
    .clk(clk), .reset(reset), .ADDR(addr_b), .WR_DATA(wr_data_b),
    .WR_STB(wr_stb_b), .RD_STB(rd_stb_b), .RD_DATA(rd_data_b),
    .RD_VALID(rd_valid_b), .LINK_UP(link_up), .BUSY(busy_b), .CTRL(ctrl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic wr_a(input logic [4:0] a, input logic [15:0] d);
    addr_a = a; wr_data_a = d; wr_stb_a = 1'b1;
    @(posedge clk); #1;
    wr_stb_a = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [4:0] a, input logic [15:0] exp);
    addr_a = a; rd_stb_a = 1'b1;
    @(posedge clk); #1;
    rd_stb_a = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid_a}, 32'd1);
    check(tag, {16'd0, rd_data_a}, {16'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; link_up = 1'b1;
    addr_a = '0; wr_data_a = '0; wr_stb_a = 1'b0; rd_stb_a = 1'b0;
    addr_b = '0; wr_data_b = '0; wr_stb_b = 1'b0; rd_stb_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", {31'd0, rd_valid_a}, 32'd0);
    check("rst_busy",     {31'd0, busy_a},     32'd0);
    check("rst_ctrl",     {16'd0, ctrl_a},     32'd0);
    check("rst_rd_data",  {16'd0, rd_data_a},  32'd0);
    reset = 1'b1;
    idle(1);

    // NUM_REGS=20 instance: address 25 is unimplemented.
    addr_b = 5'd19; wr_data_b = 16'h1919; wr_stb_b = 1'b1;
    @(posedge clk); #1;
    addr_b = 5'd25; wr_data_b = 16'hABCD;
    @(posedge clk); #1;
    wr_stb_b = 1'b0; rd_stb_b = 1'b1;
    @(posedge clk); #1;
    check("b_oor_valid", {31'd0, rd_valid_b}, 32'd1);
    check("b_oor_data",  {16'd0, rd_data_b},  32'd0);
    addr_b = 5'd19;
    @(posedge clk); #1;
    rd_stb_b = 1'b0;
    check("b_r19_data", {16'd0, rd_data_b}, 32'h1919);

    // Write i*256 everywhere, then read everything back.
    for (int i = 0; i < 32; i++) wr_a(5'(i), 16'(i * 256));
    for (int i = 0; i < 32; i++) begin
      logic [15:0] exp;
      exp = (i == 0) ? 16'h0000 : (i == 1) ? 16'h0000 : 16'(i * 256);
      rd_a($sformatf("sweep_r%0d", i), 5'(i), exp);
      idle(1);
      check($sformatf("sweep_r%0d_pulse", i), {31'd0, rd_valid_a}, 32'd0);
    end

    // LINK latch: the sweep re-armed it, so it reads 1 now.
    rd_a("link_armed", 5'd1, 16'h0004);
    link_up = 1'b0;
    idle(1);
    link_up = 1'b1;
    idle(1);
    rd_a("link_drop", 5'd1, 16'h0000);
    rd_a("link_rearm", 5'd1, 16'h0004);

    // Simultaneous read and write to reg3.
    wr_a(5'd3, 16'h0011);
    addr_a = 5'd3; wr_data_a = 16'h0022; wr_stb_a = 1'b1; rd_stb_a = 1'b1;
    @(posedge clk); #1;
    wr_stb_a = 1'b0; rd_stb_a = 1'b0;
    check("rbw_old", {16'd0, rd_data_a}, 32'h0011);
    rd_a("rbw_new", 5'd3, 16'h0022);

    // Soft reset.
    wr_a(5'd5, 16'h1234);
    wr_a(5'd0, 16'h8000);
    busy_cycles = 0;
    if (busy_a) busy_cycles++;
    check("srst_ctrl", {16'd0, ctrl_a}, 32'h8000);
    wr_a(5'd6, 16'h5555);
    if (busy_a) busy_cycles++;
    rd_a("srst_r0", 5'd0, 16'h8000);
    if (busy_a) busy_cycles++;
    rd_a("srst_r6", 5'd6, 16'h0600);
    if (busy_a) busy_cycles++;
    rd_a("srst_status", 5'd1, 16'h0005);
    if (busy_a) busy_cycles++;
    for (int k = 0; k < 40 && busy_a; k++) begin
      @(posedge clk); #1;
      if (busy_a) busy_cycles++;
    end
    check("srst_busy_cycles", 32'(busy_cycles), 32'd8);
    check("srst_busy_end", {31'd0, busy_a}, 32'd0);
    check("srst_ctrl_end", {16'd0, ctrl_a}, 32'd0);
    wr_a(5'd7, 16'h0777);
    rd_a("post_r5", 5'd5, 16'h0000);
    rd_a("post_r0", 5'd0, 16'h0000);
    rd_a("post_r7", 5'd7, 16'h0777);
    rd_a("post_status", 5'd1, 16'h0004);

    // Hardware reset on the third cycle of a soft reset.
    wr_a(5'd0, 16'h8000);
    idle(1);
    addr_a = 5'd0; rd_stb_a = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    rd_stb_a = 1'b0;
    check("abort_busy",     {31'd0, busy_a},     32'd0);
    check("abort_ctrl",     {16'd0, ctrl_a},     32'd0);
    check("abort_rd_valid", {31'd0, rd_valid_a}, 32'd0);
    reset = 1'b1;
    wr_a(5'd4, 16'h4444);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (busy_a) check("abort_no_busy", {31'd0, busy_a}, 32'd0);
    end
    rd_a("abort_r4", 5'd4, 16'h4444);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
